// File: rtl/mvm_stream.sv
// Streaming signed matrix-vector multiplier y = A*x with a single time-multiplexed MAC.
// Define MVM_SAT_EN to saturate results that do not fit in OUT_W; otherwise they wrap.
module mvm_stream #(
    parameter int W     = 8,
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             done,
    output logic             busy
);
    localparam int ACC_W = 2*W + $clog2(N);
    localparam int MN    = M*N;
    localparam int NA_W  = (N > 1) ? $clog2(N) : 1;
    localparam int MA_W  = (M > 1) ? $clog2(M) : 1;
    localparam int AA_W  = (MN > 1) ? $clog2(MN) : 1;
    localparam int MC_W  = $clog2(MN + 2);

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_A, MAC, OUT} state_t;

    state_t state_q, state_d;
    logic [NA_W-1:0] x_cnt_q, x_cnt_d;
    logic [AA_W-1:0] a_cnt_q, a_cnt_d;
    logic [MA_W-1:0] row_q, row_d;
    logic [MC_W-1:0] mac_cnt_q, mac_cnt_d;
    logic [MA_W-1:0] out_cnt_q, out_cnt_d;
    logic            done_q, done_d;
    logic            beat, issue;

    // Array depths are rounded to a power of two so counter widths index them exactly.
    logic signed [W-1:0]     x_mem [2**NA_W];
    logic signed [W-1:0]     a_mem [2**AA_W];
    logic signed [ACC_W-1:0] y_mem [2**MA_W];

    logic [2:1]              vld_pipe_q;
    logic                    p1_first_q, p1_last_q;
    logic [MA_W-1:0]         p1_row_q, wr_row_q;
    logic signed [W-1:0]     a_rd_q, x_rd_q;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] y_sel;
    logic [OUT_W-1:0]        y_conv;

    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        a_cnt_d   = a_cnt_q;
        row_d     = row_q;
        mac_cnt_d = mac_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        in_ready  = (state_q == LOAD_X) || (state_q == LOAD_A);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        beat      = in_valid && in_ready;
        issue     = (state_q == MAC) && (mac_cnt_q < MC_W'(MN));
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_X;
                x_cnt_d = '0;
                a_cnt_d = '0;
            end
            LOAD_X: if (beat) begin
                if (x_cnt_q == NA_W'(N-1)) begin
                    x_cnt_d = '0;
                    state_d = LOAD_A;
                end else begin
                    x_cnt_d = x_cnt_q + 1'b1;
                end
            end
            LOAD_A: if (beat) begin
                if (a_cnt_q == AA_W'(MN-1)) begin
                    a_cnt_d   = '0;
                    row_d     = '0;
                    mac_cnt_d = '0;
                    state_d   = MAC;
                end else begin
                    a_cnt_d = a_cnt_q + 1'b1;
                end
            end
            MAC: begin
                mac_cnt_d = mac_cnt_q + 1'b1;
                if (issue) begin
                    a_cnt_d = a_cnt_q + 1'b1;
                    if (x_cnt_q == NA_W'(N-1)) begin
                        x_cnt_d = '0;
                        row_d   = row_q + 1'b1;
                    end else begin
                        x_cnt_d = x_cnt_q + 1'b1;
                    end
                end
                // Two extra cycles drain the RAM-read and accumulate stages into y RAM.
                if (mac_cnt_q == MC_W'(MN+1)) begin
                    state_d   = OUT;
                    out_cnt_d = '0;
                end
            end
            OUT: if (out_ready) begin
                if (out_cnt_q == MA_W'(M-1)) begin
                    state_d   = IDLE;
                    out_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod  = a_rd_q * x_rd_q;
    assign acc_d = (p1_first_q ? '0 : acc_q) + ACC_W'(prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_cnt_q    <= '0;
            a_cnt_q    <= '0;
            row_q      <= '0;
            mac_cnt_q  <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_row_q   <= '0;
            wr_row_q   <= '0;
            a_rd_q     <= '0;
            x_rd_q     <= '0;
            acc_q      <= '0;
        end else begin
            state_q       <= state_d;
            x_cnt_q       <= x_cnt_d;
            a_cnt_q       <= a_cnt_d;
            row_q         <= row_d;
            mac_cnt_q     <= mac_cnt_d;
            out_cnt_q     <= out_cnt_d;
            done_q        <= done_d;
            vld_pipe_q[1] <= issue;
            vld_pipe_q[2] <= vld_pipe_q[1] && p1_last_q;
            p1_first_q    <= (x_cnt_q == '0);
            p1_last_q     <= (x_cnt_q == NA_W'(N-1));
            p1_row_q      <= row_q;
            wr_row_q      <= p1_row_q;
            a_rd_q        <= a_mem[a_cnt_q];
            x_rd_q        <= x_mem[x_cnt_q];
            if (vld_pipe_q[1]) acc_q <= acc_d;
        end
    end

    // Operand and result RAMs are fully rewritten by every job, so they carry no reset.
    always_ff @(posedge clk) begin
        if (beat && state_q == LOAD_X) x_mem[x_cnt_q] <= data_in;
        if (beat && state_q == LOAD_A) a_mem[a_cnt_q] <= data_in;
        if (vld_pipe_q[2])             y_mem[wr_row_q] <= acc_q;
    end

    assign y_sel = y_mem[out_cnt_q];

    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign y_conv = OUT_W'(y_sel);
        end else begin : g_narrow
`ifdef MVM_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                y_conv = OUT_W'(y_sel);
                if (y_sel > SAT_MAX)      y_conv = OUT_W'(SAT_MAX);
                else if (y_sel < SAT_MIN) y_conv = OUT_W'(SAT_MIN);
            end
`else
            assign y_conv = OUT_W'(y_sel);
`endif
        end
    endgenerate

    assign data_out = out_valid ? y_conv : '0;
    assign done     = done_q;
endmodule
